char_rom_arbiter: RTL and testbench
===================================

CHAR_ROM_ARBITER -- requirements
Module: char_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing one character ROM; legal range 2..8.
REQ-002 Parameter ROM_LATENCY, default 1: cycles from ROM address register to valid char_code; legal range 1..4.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N_REQ  per-requester request; addr[i] valid while req[i] high.
REQ-006 addr  input  N_REQ*12  packed char_xy addresses; requester i at bits [12*i+11:12*i].
REQ-007 gnt  output  N_REQ  one-cycle pulse per requester: request accepted and issued to ROM this cycle.
REQ-008 rsp_valid  output  N_REQ  one-cycle pulse: rsp_data holds the character for requester i.
REQ-009 rsp_data  output  7  character code returned by the ROM, shared by all requesters.
REQ-010 rom_char_xy  output  12  registered address driven to the character ROM.
REQ-011 rom_char_code  input  7  ROM output, valid ROM_LATENCY cycles after rom_char_xy changes.
REQ-012 busy  output  1  high while any lookup is in flight (issued, response not yet delivered).

Function
REQ-013 Arbitration each cycle over eligible requests, eligible = req[i] and not gnt[i] (a requester whose gnt is high this cycle is masked, so held req does not double-grant).
REQ-014 Round-robin: search starts at index (last_winner+1) mod N_REQ, wraps; first eligible index wins; last_winner resets to N_REQ-1 so index 0 wins first.
REQ-015 Winner registered: next cycle rom_char_xy = winner's addr, gnt[winner]=1, last_winner=winner; at most one gnt bit high per cycle.
REQ-016 No eligible request: gnt = 0, rom_char_xy holds previous value, last_winner unchanged, no tag issued.
REQ-017 Requester i deasserts req or presents a new addr in the cycle gnt[i] is high; a req still high then is a new request eligible one cycle later.
REQ-018 Tag pipeline: each issue pushes {valid, winner index} into a shift register of depth ROM_LATENCY+1; empty slots carry valid=0.
REQ-019 Response: when tag reaches the end, rsp_valid[idx]=1 and rsp_data=rom_char_code registered that cycle; total latency req sampled -> rsp_valid = ROM_LATENCY+2 cycles.
REQ-020 Throughput: one issue per cycle whenever any eligible request exists; responses delivered in issue order, never dropped or reordered.
REQ-021 rsp_data holds its last value when rsp_valid = 0.
REQ-022 busy = OR of valid bits in the tag pipeline, registered alongside it.
REQ-023 req changes of non-winners do not affect issued lookups; addr of non-winners ignored.

Reset
REQ-024 rst_n low asynchronously clears: gnt=0, rsp_valid=0, rsp_data=0, rom_char_xy=0, busy=0, all tags invalid, last_winner=N_REQ-1.
REQ-025 Reset mid-operation discards in-flight lookups; no rsp_valid pulse appears after rst_n rises for requests issued before reset.
REQ-026 First arbitration on the first rising edge with rst_n high.

Verification
REQ-027 Single: req[1]=1, addr1=12'h00F at cycle 0, dropped on gnt -> gnt[1] at cycle 1, rom_char_xy=12'h00F, rsp_valid[1] with data "S" at cycle 3 (ROM_LATENCY=1, gameover ROM model).
REQ-028 Contention: req=3'b111 held continuously, distinct addrs -> gnt order 0,1,2,0,1,2..., one gnt per cycle, responses in same order, each matching its addr.
REQ-029 Hold without drop: req[0] held high alone -> gnt[0] every other cycle, no duplicate responses per grant.
REQ-030 Idle gap: no requests for 5 cycles then req[2] -> gnt[2] (pointer from last winner), rom_char_xy unchanged during gap, busy low during gap.
REQ-031 Reset mid-flight: pulse rst_n low one cycle after gnt[0] -> all outputs 0 immediately, no rsp_valid afterwards, next req[0] granted normally.
REQ-032 ROM_LATENCY=3 build: repeat contention scenario -> latency 5 cycles, order and data preserved.

Source files
------------

// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one character ROM among N_REQ requesters.
// A tag pipeline follows each lookup so the response returns to its owner.
module char_rom_arbiter #(
  parameter int N_REQ       = 3,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*12-1:0]   addr,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [6:0]            rsp_data,
  output logic [11:0]           rom_char_xy,
  input  logic [6:0]            rom_char_code,
  output logic                  busy
);
  localparam int IW    = $clog2(N_REQ);
  localparam int DEPTH = ROM_LATENCY + 1;

  logic [N_REQ-1:0]            gnt_q, gnt_d;
  logic [11:0]                 xy_q, xy_d;
  logic [IW-1:0]               last_q, last_d;
  logic [DEPTH-1:0]            tagValid_q, tagValid_d;
  logic [DEPTH-1:0][IW-1:0]    tagIdx_q, tagIdx_d;
  logic [N_REQ-1:0]            rspValid_q, rspValid_d;
  logic [6:0]                  rspData_q, rspData_d;
  logic                        busy_q, busy_d;

  logic [N_REQ-1:0]            eligible;
  logic                        hiFound, loFound, found;
  logic [IW-1:0]               hiIdx, loIdx, winner;

  // Lowest eligible index above the last winner wins; otherwise wrap to the
  // lowest eligible index at or below it. Requesters granted now are masked.
  always_comb begin
    eligible = req & ~gnt_q;
    hiFound  = 1'b0;
    loFound  = 1'b0;
    hiIdx    = '0;
    loIdx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i > int'(last_q)) begin
          hiFound = 1'b1;
          hiIdx   = IW'(i);
        end else begin
          loFound = 1'b1;
          loIdx   = IW'(i);
        end
      end
    end
    found  = hiFound | loFound;
    winner = hiFound ? hiIdx : loIdx;
  end

  always_comb begin
    gnt_d      = '0;
    xy_d       = xy_q;
    last_d     = last_q;
    tagValid_d = {tagValid_q[DEPTH-2:0], found};
    tagIdx_d   = {tagIdx_q[DEPTH-2:0], winner};
    busy_d     = |tagValid_d;
    rspValid_d = '0;
    rspData_d  = rspData_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (found && (winner == IW'(i))) begin
        gnt_d[i] = 1'b1;
        xy_d     = addr[12*i +: 12];
      end
    end
    if (found) begin
      last_d = winner;
    end
    // The oldest tag lines up with the ROM output for its address.
    if (tagValid_q[DEPTH-1]) begin
      rspData_d = rom_char_code;
      for (int i = 0; i < N_REQ; i++) begin
        if (tagIdx_q[DEPTH-1] == IW'(i)) begin
          rspValid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      xy_q       <= '0;
      last_q     <= IW'(N_REQ - 1);
      tagValid_q <= '0;
      tagIdx_q   <= '0;
      rspValid_q <= '0;
      rspData_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      xy_q       <= xy_d;
      last_q     <= last_d;
      tagValid_q <= tagValid_d;
      tagIdx_q   <= tagIdx_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign rom_char_xy = xy_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_data    = rspData_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Bench for char_rom_arbiter: ROM_LATENCY=1 and ROM_LATENCY=3 instances share
// one stimulus stream and are checked against a cycle-history reference model.
module tb_char_rom_arbiter;
  localparam int N    = 3;
  localparam int HIST = 2048;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req;
  logic [N*12-1:0]  addr;

  logic [N-1:0]     gntA [2];
  logic [N-1:0]     rspValidA [2];
  logic [6:0]       rspDataA [2];
  logic [6:0]       codeA [2];
  logic [11:0]      xyA [2];
  logic             busyA [2];
  logic [6:0]       romS1 = '0;
  logic [6:0]       romS2 = '0;

  int               nChecks;
  int               nFail;
  int               cyc;
  int               epochStart;
  int               lastW;
  logic             issueValid [HIST];
  int               issueIdx [HIST];
  logic [11:0]      issueAddr [HIST];
  logic [N-1:0]     expGnt;
  logic [11:0]      expXy;
  logic [N-1:0]     expRspValid [2];
  logic [6:0]       expRspData [2];
  logic             expBusy [2];

  always #5 clk = ~clk;

  char_rom_arbiter #(.N_REQ(N), .ROM_LATENCY(1)) dutLat1 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .gnt(gntA[0]),
    .rsp_valid(rspValidA[0]), .rsp_data(rspDataA[0]), .rom_char_xy(xyA[0]),
    .rom_char_code(codeA[0]), .busy(busyA[0])
  );

  char_rom_arbiter #(.N_REQ(N), .ROM_LATENCY(3)) dutLat3 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .gnt(gntA[1]),
    .rsp_valid(rspValidA[1]), .rsp_data(rspDataA[1]), .rom_char_xy(xyA[1]),
    .rom_char_code(codeA[1]), .busy(busyA[1])
  );

  // Gameover-style character ROM: address 12'h00F returns 'S' (7'h53).
  function automatic logic [6:0] romF(input logic [11:0] a);
    return a[6:0] ^ 7'h5C;
  endfunction

  // ROM models: output is valid one or three cycles after the address changes.
  initial codeA[0] = '0;
  initial codeA[1] = '0;
  always @(posedge clk) begin
    codeA[0] <= romF(xyA[0]);
    romS1    <= romF(xyA[1]);
    romS2    <= romS1;
    codeA[1] <= romS2;
  end

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    nChecks++;
    assert (obs === expv)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("gnt_L%0d_c%0d", latOf(k), cyc), 16'(gntA[k]), 16'(expGnt));
      checkOutput($sformatf("xy_L%0d_c%0d", latOf(k), cyc), 16'(xyA[k]), 16'(expXy));
      checkOutput($sformatf("rspv_L%0d_c%0d", latOf(k), cyc), 16'(rspValidA[k]), 16'(expRspValid[k]));
      checkOutput($sformatf("rspd_L%0d_c%0d", latOf(k), cyc), 16'(rspDataA[k]), 16'(expRspData[k]));
      checkOutput($sformatf("busy_L%0d_c%0d", latOf(k), cyc), 16'(busyA[k]), 16'(expBusy[k]));
    end
  endtask

  task automatic modelReset();
    expGnt     = '0;
    expXy      = '0;
    lastW      = N - 1;
    epochStart = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      expRspValid[k] = '0;
      expRspData[k]  = '0;
      expBusy[k]     = 1'b0;
    end
  endtask

  // One clock: the model consumes the inputs seen at the edge, then the DUT
  // outputs are compared 1 time unit later.
  task automatic stepCycle();
    logic [N-1:0] elig;
    int           win;
    int           g;
    @(posedge clk);
    cyc++;
    if (cyc >= HIST) begin
      $display("[TB] FAIL history_overflow observed=%0d limit=%0d", cyc, HIST);
      $fatal(1, "[TB] history exhausted");
    end
    issueValid[cyc] = 1'b0;
    if (!rst_n) begin
      modelReset();
    end else begin
      elig = req & ~expGnt;
      win  = -1;
      for (int d = 1; d <= N; d++) begin
        if (win < 0 && elig[(lastW + d) % N]) win = (lastW + d) % N;
      end
      if (win >= 0) begin
        issueValid[cyc] = 1'b1;
        issueIdx[cyc]   = win;
        issueAddr[cyc]  = addr[win*12 +: 12];
        expGnt          = N'(1) << win;
        expXy           = addr[win*12 +: 12];
        lastW           = win;
      end else begin
        expGnt = '0;
      end
      for (int k = 0; k < 2; k++) begin
        g = cyc - (latOf(k) + 1);
        if (g >= epochStart && issueValid[g]) begin
          expRspValid[k] = N'(1) << issueIdx[g];
          expRspData[k]  = romF(issueAddr[g]);
        end else begin
          expRspValid[k] = '0;
        end
        expBusy[k] = 1'b0;
        for (int h = cyc - latOf(k); h <= cyc; h++) begin
          if (h >= epochStart && issueValid[h]) expBusy[k] = 1'b1;
        end
      end
    end
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
    for (int i = 0; i < N; i++) addr[i*12 +: 12] = 12'($urandom());
  endtask

  task automatic drain(input int n);
    req = '0;
    repeat (n) stepCycle();
  endtask

  task automatic waitGnt(input int i);
    for (int n = 0; n < 8; n++) begin
      stepCycle();
      if (expGnt[i]) break;
    end
    checkOutput($sformatf("wait_gnt%0d", i), 16'(gntA[0][i]), 16'd1);
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    cyc     = 0;
    for (int h = 0; h < HIST; h++) issueValid[h] = 1'b0;
    req   = '0;
    addr  = '0;
    rst_n = 1'b0;
    modelReset();
    stepCycle();
    stepCycle();
    rst_n = 1'b1;

    // Single lookup from requester 1, dropped on grant.
    req[1]          = 1'b1;
    addr[12 +: 12]  = 12'h00F;
    stepCycle();
    checkOutput("single_gnt", 16'(gntA[0]), 16'b010);
    checkOutput("single_xy", 16'(xyA[0]), 16'h00F);
    req[1] = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("single_rspv_L1", 16'(rspValidA[0]), 16'b010);
    checkOutput("single_rspd_L1", 16'(rspDataA[0]), 16'h53);
    stepCycle();
    stepCycle();
    checkOutput("single_rspv_L3", 16'(rspValidA[1]), 16'b010);
    checkOutput("single_rspd_L3", 16'(rspDataA[1]), 16'h53);
    drain(4);

    // Full contention; each granted requester presents a fresh address.
    applyStimulus(3'b111);
    repeat (24) begin
      stepCycle();
      for (int i = 0; i < N; i++) begin
        if (expGnt[i]) addr[i*12 +: 12] = 12'($urandom());
      end
    end
    drain(6);

    // Requester 0 holds req without dropping it.
    applyStimulus(3'b001);
    repeat (10) stepCycle();
    drain(6);

    // Idle gap followed by a lone request from requester 2.
    drain(5);
    applyStimulus(3'b100);
    waitGnt(2);
    req = '0;
    drain(6);

    // Reset pulse one cycle after a grant discards the in-flight lookup.
    applyStimulus(3'b001);
    waitGnt(0);
    req = '0;
    stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    stepCycle();
    rst_n = 1'b1;
    drain(6);
    applyStimulus(3'b001);
    waitGnt(0);
    req = '0;
    drain(6);

    // Random traffic: requests rise at random and drop or renew on grant.
    applyStimulus('0);
    repeat (200) begin
      stepCycle();
      for (int i = 0; i < N; i++) begin
        if (expGnt[i]) begin
          req[i]           = ($urandom_range(0, 1) == 1);
          addr[i*12 +: 12] = 12'($urandom());
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]           = 1'b1;
          addr[i*12 +: 12] = 12'($urandom());
        end
      end
    end
    drain(8);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
